ahb_bus_arbiter: RTL and testbench

//  Shares the single AHB slave port of the AHB-APB bridge between NUM_MST AHB masters.

---
 rtl/bridge_pkg.sv | 8 +
 rtl/arb_rr_pick.sv | 24 ++
 rtl/ahb_bus_arbiter.sv | 93 +++++++++
 tb/tb_ahb_bus_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// bridge_pkg: shared HTRANS encodings and arbiter FSM state type for the AHB-APB bridge
package bridge_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   typedef enum logic {PARK, OWN} arb_state_t;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational round-robin picker, first requester after ptr in ascending modulo order
module arb_rr_pick #(
   parameter int N = 3,
   localparam int MW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [MW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          vld
);
   logic [MW-1:0] j;
   always_comb begin
      gnt = '0;
      vld = 1'b0;
      j = '0;
      for (int k = 1; k <= N; k++) begin
         j = MW'((int'(ptr) + k) % N);
         if (!vld && req[j]) begin
            gnt[j] = 1'b1;
            vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB master arbiter with address/data-phase muxing to one slave port.
// Define ARB_TENURE_LIMIT_EN to preempt an owner after MAX_BEATS accepted beats when others request.
module ahb_bus_arbiter import bridge_pkg::*; #(
   parameter int NUM_MST = 3,
   parameter int MAX_BEATS = 16,
   parameter int AW = 32,
   parameter int DW = 32,
   localparam int MW = $clog2(NUM_MST)
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [NUM_MST-1:0]    HBUSREQ,
   input  logic [NUM_MST*AW-1:0] HADDR_M,
   input  logic [NUM_MST*2-1:0]  HTRANS_M,
   input  logic [NUM_MST-1:0]    HWRITE_M,
   input  logic [NUM_MST*DW-1:0] HWDATA_M,
   input  logic                  HREADYOUT,
   output logic [NUM_MST-1:0]    HGRANT,
   output logic [MW-1:0]         HMASTER,
   output logic [AW-1:0]         HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [DW-1:0]         HWDATA,
   output logic                  HREADY
);
   if (NUM_MST < 2 || NUM_MST > 8 || MAX_BEATS < 1) begin : g_bad_cfg
      $error("ahb_bus_arbiter: unsupported NUM_MST/MAX_BEATS");
   end
   arb_state_t state, state_nxt;
   logic [NUM_MST-1:0] grant, grant_nxt, pick;
   logic [MW-1:0] ptr, ptr_nxt, gidx, pidx, hmaster, hmaster_d;
   logic pick_vld, expire;
   arb_rr_pick #(.N(NUM_MST)) u_pick (.req(HBUSREQ), .ptr(ptr), .gnt(pick), .vld(pick_vld));
   always_comb begin
      gidx = '0;
      pidx = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (grant[i]) gidx = MW'(i);
         if (pick[i]) pidx = MW'(i);
      end
   end
   // owner keeps the bus while requesting; otherwise hand over to the next RR requester
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      ptr_nxt = ptr;
      if (!pick_vld) begin
         state_nxt = PARK;
         grant_nxt = NUM_MST'(1);
      end else if (state == PARK || !(|(HBUSREQ & grant)) || expire) begin
         state_nxt = OWN;
         grant_nxt = pick;
         ptr_nxt = pidx;
      end
   end
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= PARK;
         grant <= NUM_MST'(1);
         ptr <= '0;
         hmaster <= '0;
         hmaster_d <= '0;
      end else if (HREADYOUT) begin
         state <= state_nxt;
         grant <= grant_nxt;
         ptr <= ptr_nxt;
         hmaster <= gidx;
         hmaster_d <= hmaster;
      end
   end
`ifdef ARB_TENURE_LIMIT_EN
   localparam int CW = $clog2(MAX_BEATS + 1);
   logic [CW-1:0] cnt;
   logic beat;
   // only beats issued by the current grant holder count toward its tenure
   assign beat = (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) && hmaster == gidx;
   assign expire = cnt == CW'(MAX_BEATS) && |(HBUSREQ & ~grant);
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) cnt <= '0;
      else if (HREADYOUT) cnt <= (state == PARK || grant_nxt != grant) ? '0 :
                                 (beat && cnt != CW'(MAX_BEATS)) ? cnt + 1'b1 : cnt;
   end
`else
   assign expire = 1'b0;
`endif
   assign HGRANT = grant;
   assign HMASTER = hmaster;
   assign HADDR = HADDR_M[hmaster*AW +: AW];
   assign HTRANS = HTRANS_M[hmaster*2 +: 2];
   assign HWRITE = HWRITE_M[hmaster];
   assign HWDATA = HWDATA_M[hmaster_d*DW +: DW];
   assign HREADY = HREADYOUT;
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed table plus hand sequences for reset, async reset and tenure limit
module tb_ahb_bus_arbiter;
   localparam int N = 3, AW = 32, DW = 32, MB = 4;
   logic HCLK = 1'b0, HRESETn = 1'b0, HREADYOUT, HWRITE, HREADY;
   logic [N-1:0] HBUSREQ, HWRITE_M, HGRANT;
   logic [N*AW-1:0] HADDR_M;
   logic [N*2-1:0] HTRANS_M;
   logic [N*DW-1:0] HWDATA_M;
   logic [1:0] HMASTER, HTRANS;
   logic [AW-1:0] HADDR;
   logic [DW-1:0] HWDATA;
   logic [AW-1:0] addr [N];
   logic [DW-1:0] wdata [N];
   logic [1:0] tr [N];
   int total = 0, bad = 0;
   typedef struct {
      logic [2:0] req;
      logic rdy;
      logic [2:0] g;
      int m;
      int d;
   } vec_t;
   vec_t tbl [22];

   ahb_bus_arbiter #(.NUM_MST(N), .MAX_BEATS(MB), .AW(AW), .DW(DW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HADDR_M(HADDR_M),
      .HTRANS_M(HTRANS_M), .HWRITE_M(HWRITE_M), .HWDATA_M(HWDATA_M), .HREADYOUT(HREADYOUT),
      .HGRANT(HGRANT), .HMASTER(HMASTER), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HWDATA(HWDATA), .HREADY(HREADY));

   always #5 HCLK = ~HCLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [2:0] r, input logic y);
      HBUSREQ = r;
      HREADYOUT = y;
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      int n;
      addr = '{32'h0000_0100, 32'h0000_0200, 32'h0000_1000};
      wdata = '{32'h0000_0000, 32'h1111_1111, 32'hDEAD_BEEF};
      tr = '{2'b00, 2'b11, 2'b10};
      HADDR_M = {addr[2], addr[1], addr[0]};
      HWDATA_M = {wdata[2], wdata[1], wdata[0]};
      HTRANS_M = {tr[2], tr[1], tr[0]};
      HWRITE_M = 3'b101;
      tbl[0]  = '{3'b100, 1'b1, 3'b100, 0, 0};
      tbl[1]  = '{3'b100, 1'b1, 3'b100, 2, 0};
      tbl[2]  = '{3'b100, 1'b1, 3'b100, 2, 2};
      tbl[3]  = '{3'b010, 1'b1, 3'b010, 2, 2};
      tbl[4]  = '{3'b010, 1'b1, 3'b010, 1, 2};
      tbl[5]  = '{3'b100, 1'b0, 3'b010, 1, 2};
      tbl[6]  = '{3'b100, 1'b0, 3'b010, 1, 2};
      tbl[7]  = '{3'b100, 1'b0, 3'b010, 1, 2};
      tbl[8]  = '{3'b100, 1'b1, 3'b100, 1, 1};
      tbl[9]  = '{3'b100, 1'b1, 3'b100, 2, 1};
      tbl[10] = '{3'b100, 1'b0, 3'b100, 2, 1};
      tbl[11] = '{3'b100, 1'b1, 3'b100, 2, 2};
      tbl[12] = '{3'b000, 1'b1, 3'b001, 2, 2};
      tbl[13] = '{3'b000, 1'b1, 3'b001, 0, 2};
      tbl[14] = '{3'b000, 1'b1, 3'b001, 0, 0};
      tbl[15] = '{3'b011, 1'b1, 3'b001, 0, 0};
      tbl[16] = '{3'b011, 1'b1, 3'b001, 0, 0};
      tbl[17] = '{3'b010, 1'b1, 3'b010, 0, 0};
      tbl[18] = '{3'b111, 1'b1, 3'b010, 1, 0};
      tbl[19] = '{3'b101, 1'b1, 3'b100, 1, 1};
      tbl[20] = '{3'b001, 1'b1, 3'b001, 2, 1};
      tbl[21] = '{3'b001, 1'b1, 3'b001, 0, 2};

      HBUSREQ = 3'b111;
      HREADYOUT = 1'b1;
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst grant", 32'(HGRANT), 32'h1);
      chk("rst hmaster", 32'(HMASTER), 32'h0);
      chk("rst haddr", HADDR, addr[0]);
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;
      chk("first grant", 32'(HGRANT), 32'h2);
      chk("first hmaster", 32'(HMASTER), 32'h0);
      step(3'b111, 1'b1);
      chk("first hmaster+1", 32'(HMASTER), 32'h1);
      chk("first haddr+1", HADDR, addr[1]);
      step(3'b111, 1'b1);
      chk("first hwdata+2", HWDATA, wdata[1]);
      @(negedge HCLK);
      HRESETn = 1'b0;
      #1;
      chk("async grant", 32'(HGRANT), 32'h1);
      chk("async hmaster", 32'(HMASTER), 32'h0);
      chk("async haddr", HADDR, addr[0]);
      chk("async hwdata", HWDATA, wdata[0]);

      HBUSREQ = 3'b000;
      @(negedge HCLK);
      HRESETn = 1'b1;
      for (int i = 0; i < 22; i++) begin
         step(tbl[i].req, tbl[i].rdy);
         chk($sformatf("v%0d grant", i), 32'(HGRANT), 32'(tbl[i].g));
         chk($sformatf("v%0d hmaster", i), 32'(HMASTER), 32'(tbl[i].m));
         chk($sformatf("v%0d haddr", i), HADDR, addr[tbl[i].m]);
         chk($sformatf("v%0d htrans", i), 32'(HTRANS), 32'(tr[tbl[i].m]));
         chk($sformatf("v%0d hwrite", i), 32'(HWRITE), 32'(HWRITE_M[tbl[i].m]));
         chk($sformatf("v%0d hwdata", i), HWDATA, wdata[tbl[i].d]);
         chk($sformatf("v%0d hready", i), 32'(HREADY), 32'(tbl[i].rdy));
      end

`ifdef ARB_TENURE_LIMIT_EN
      HRESETn = 1'b0;
      HTRANS_M = {2'b00, 2'b10, 2'b10};
      HBUSREQ = 3'b001;
      @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (20) step(3'b001, 1'b1);
      chk("tenure sole grant", 32'(HGRANT), 32'h1);
      step(3'b011, 1'b1);
      chk("tenure preempt", 32'(HGRANT), 32'h2);
      n = 0;
      for (int k = 0; k < 20 && HGRANT == 3'b010; k++) begin
         step(3'b011, 1'b1);
         if (HGRANT == 3'b010) n++;
      end
      chk("tenure m1 cycles", 32'(n), 32'(MB + 1));
      chk("tenure back to m0", 32'(HGRANT), 32'h1);
`else
      n = 0;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
